// File: rtl/rgb_pwm_if.sv
// Colour word, enable and LED/period outputs of the RGB PWM driver.
// The master side supplies colour and enable; the slave side is the driver.
interface rgb_pwm_if;
  logic        enable;
  logic [23:0] rgb;
  logic        led_r;
  logic        led_g;
  logic        led_b;
  logic        period_start;

  modport master (
    output enable,
    output rgb,
    input  led_r,
    input  led_g,
    input  led_b,
    input  period_start
  );

  modport slave (
    input  enable,
    input  rgb,
    output led_r,
    output led_g,
    output led_b,
    output period_start
  );
endinterface

// File: rtl/rgb_pwm_driver.sv
// 8-bit, 255-step PWM driver for an RGB LED with duty latched at period boundaries.
// Define RGB_PWM_ACTIVE_LOW_EN for common-anode LEDs (inverted led_* outputs).
module rgb_pwm_driver #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic      clk,
  input  logic      rst,
  rgb_pwm_if.slave  pwm_if
);

`ifdef RGB_PWM_ACTIVE_LOW_EN
  localparam logic LED_INV = 1'b1;
`else
  localparam logic LED_INV = 1'b0;
`endif

  localparam logic [15:0] PRESCALE_M1 = 16'(PRESCALE - 32'd1);
  localparam logic [7:0]  PWM_LAST    = 8'd254;

  logic [15:0] pre_cnt_r;
  logic [7:0]  pwm_cnt_r;
  logic [7:0]  sh_red_r;
  logic [7:0]  sh_grn_r;
  logic [7:0]  sh_blu_r;
  logic        led_r_r;
  logic        led_g_r;
  logic        led_b_r;
  logic        period_start_r;

  logic        tick_s;
  logic        load_s;
  logic [7:0]  duty_r_s;
  logic [7:0]  duty_g_s;
  logic [7:0]  duty_b_s;

  // Prescaler tick, load-point detection and duty source selection
  always_comb begin
    tick_s   = 1'b0;
    load_s   = 1'b0;
    duty_r_s = sh_red_r;
    duty_g_s = sh_grn_r;
    duty_b_s = sh_blu_r;
    if (pre_cnt_r == PRESCALE_M1) begin
      tick_s = 1'b1;
    end else begin
      tick_s = 1'b0;
    end
    if (pwm_if.enable && (pre_cnt_r == 16'd0) && (pwm_cnt_r == 8'd0)) begin
      load_s = 1'b1;
    end else begin
      load_s = 1'b0;
    end
    // At the load point the live rgb word is used so the first count step is not stale
    if (load_s) begin
      duty_r_s = pwm_if.rgb[23:16];
      duty_g_s = pwm_if.rgb[15:8];
      duty_b_s = pwm_if.rgb[7:0];
    end else begin
      duty_r_s = sh_red_r;
      duty_g_s = sh_grn_r;
      duty_b_s = sh_blu_r;
    end
  end

  // Counters, shadow duty registers and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt_r      <= 16'd0;
      pwm_cnt_r      <= 8'd0;
      sh_red_r       <= 8'd0;
      sh_grn_r       <= 8'd0;
      sh_blu_r       <= 8'd0;
      led_r_r        <= LED_INV;
      led_g_r        <= LED_INV;
      led_b_r        <= LED_INV;
      period_start_r <= 1'b0;
    end else if (!pwm_if.enable) begin
      pre_cnt_r      <= 16'd0;
      pwm_cnt_r      <= 8'd0;
      led_r_r        <= LED_INV;
      led_g_r        <= LED_INV;
      led_b_r        <= LED_INV;
      period_start_r <= 1'b0;
    end else begin
      if (tick_s) begin
        pre_cnt_r <= 16'd0;
        if (pwm_cnt_r == PWM_LAST) begin
          pwm_cnt_r <= 8'd0;
        end else begin
          pwm_cnt_r <= pwm_cnt_r + 8'd1;
        end
      end else begin
        pre_cnt_r <= pre_cnt_r + 16'd1;
      end
      if (load_s) begin
        sh_red_r <= pwm_if.rgb[23:16];
        sh_grn_r <= pwm_if.rgb[15:8];
        sh_blu_r <= pwm_if.rgb[7:0];
      end else begin
        sh_red_r <= sh_red_r;
        sh_grn_r <= sh_grn_r;
        sh_blu_r <= sh_blu_r;
      end
      led_r_r        <= (pwm_cnt_r < duty_r_s) ^ LED_INV;
      led_g_r        <= (pwm_cnt_r < duty_g_s) ^ LED_INV;
      led_b_r        <= (pwm_cnt_r < duty_b_s) ^ LED_INV;
      period_start_r <= load_s;
    end
  end

  assign pwm_if.led_r        = led_r_r;
  assign pwm_if.led_g        = led_g_r;
  assign pwm_if.led_b        = led_b_r;
  assign pwm_if.period_start = period_start_r;

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Self-checking bench for rgb_pwm_driver: a vector table plus multi-period sequences.
// Honours RGB_PWM_ACTIVE_LOW_EN so expectations follow the LED polarity.
module tb_rgb_pwm_driver;

`ifdef RGB_PWM_ACTIVE_LOW_EN
  localparam logic INV = 1'b1;
`else
  localparam logic INV = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  rgb_pwm_if if_a ();
  rgb_pwm_if if_b ();

  rgb_pwm_driver #(.PRESCALE(1)) dut_a (.clk(clk), .rst(rst), .pwm_if(if_a));
  rgb_pwm_driver #(.PRESCALE(4)) dut_b (.clk(clk), .rst(rst), .pwm_if(if_b));

  typedef struct {
    logic        rst;
    logic        en;
    logic [23:0] rgb;
    logic [2:0]  led;
    logic        ps;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_in(input logic r, input logic e, input logic [23:0] c);
    rst         = r;
    if_a.enable = e;
    if_b.enable = e;
    if_a.rgb    = c;
    if_b.rgb    = c;
  endtask

  // Logical (active-high) LED levels of one DUT
  function automatic logic [2:0] leds(input int sel);
    if (sel == 0) return {if_a.led_r, if_a.led_g, if_a.led_b} ^ {3{INV}};
    else          return {if_b.led_r, if_b.led_g, if_b.led_b} ^ {3{INV}};
  endfunction

  function automatic logic ps_of(input int sel);
    if (sel == 0) return if_a.period_start;
    else          return if_b.period_start;
  endfunction

  // Reset both DUTs, then release with enable=1; the following edge is the first load point
  task automatic start(input logic [23:0] c);
    set_in(1'b1, 1'b1, c);
    @(posedge clk);
    #1;
    set_in(1'b0, 1'b1, c);
  endtask

  // Count LED high cycles and check period_start falls exactly on period boundaries
  task automatic measure(input string name, input int sel, input int ncyc, input int per,
                         input int off, input int er, input int eg, input int eb);
    int hr = 0;
    int hg = 0;
    int hb = 0;
    int bad_ps = 0;
    logic [2:0] o;
    for (int k = 0; k < ncyc; k++) begin
      @(posedge clk);
      #1;
      o = leds(sel);
      hr += int'(o[2]);
      hg += int'(o[1]);
      hb += int'(o[0]);
      if (ps_of(sel) != (((k + off) % per) == 0)) bad_ps++;
    end
    check({name, "_hi_r"}, hr, er);
    check({name, "_hi_g"}, hg, eg);
    check({name, "_hi_b"}, hb, eb);
    check({name, "_ps_misplaced"}, bad_ps, 0);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b1, 24'hFFFFFF, 3'b000, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 24'hFFFFFF, 3'b000, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 24'hFFFFFF, 3'b000, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 24'hFFFFFF, 3'b111, 1'b1};
    vecs[4]  = '{1'b0, 1'b1, 24'hFFFFFF, 3'b111, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 24'hFFFFFF, 3'b000, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 24'h00FFFF, 3'b011, 1'b1};
    vecs[7]  = '{1'b0, 1'b1, 24'hFF0000, 3'b011, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 24'h808080, 3'b000, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 24'h808080, 3'b111, 1'b1};
    vecs[10] = '{1'b0, 1'b1, 24'h000000, 3'b111, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 24'h000000, 3'b000, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 24'h000000, 3'b000, 1'b1};
    vecs[13] = '{1'b0, 1'b1, 24'hFFFFFF, 3'b000, 1'b0};

    set_in(1'b1, 1'b1, 24'hFFFFFF);
    for (int i = 0; i < 14; i++) begin
      set_in(vecs[i].rst, vecs[i].en, vecs[i].rgb);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_led", i), int'(leds(0)), int'(vecs[i].led));
      check($sformatf("vec%0d_ps", i), int'(ps_of(0)), int'(vecs[i].ps));
    end

    // Full red over three periods
    start(24'hFF0000);
    measure("red3", 0, 765, 255, 0, 765, 0, 0);

    // Half blue at both prescale settings
    start(24'h000080);
    measure("blue_p1", 0, 255, 255, 0, 0, 0, 128);
    start(24'h000080);
    measure("blue_p4", 1, 2040, 1020, 0, 0, 0, 1024);

    // Colour change mid-period waits for the next period
    start(24'h000000);
    measure("late_a", 0, 100, 255, 0, 0, 0, 0);
    set_in(1'b0, 1'b1, 24'h00FF00);
    measure("late_b", 0, 410, 255, 100, 0, 255, 0);

    // Enable dropped mid-period, then re-enabled with a new colour
    start(24'hFFFFFF);
    measure("en_a", 0, 50, 255, 0, 50, 50, 50);
    set_in(1'b0, 1'b0, 24'hFFFFFF);
    @(posedge clk);
    #1;
    check("en_off_led", int'(leds(0)), 0);
    check("en_off_ps", int'(ps_of(0)), 0);
    set_in(1'b0, 1'b1, 24'h00FFFF);
    measure("en_b", 0, 255, 255, 0, 0, 255, 255);

    // One-cycle reset mid-period
    start(24'h808080);
    measure("rst_a", 0, 70, 255, 0, 70, 70, 70);
    set_in(1'b1, 1'b1, 24'h808080);
    @(posedge clk);
    #1;
    check("rst_mid_led", int'(leds(0)), 0);
    check("rst_mid_ps", int'(ps_of(0)), 0);
    check("rst_mid_raw_r", int'(if_a.led_r), int'(INV));
    set_in(1'b0, 1'b1, 24'h808080);
    measure("rst_b", 0, 255, 255, 0, 128, 128, 128);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rgb_pwm_driver.md
Name: rgb_pwm_driver

Overview:
- Downstream stage of the 3-bit colour to 24-bit RGB converter.
- Consumes its 24-bit rgb word and drives three LED pins (R, G, B) with 8-bit PWM, so the LED shows the intended colour and brightness.
- Duty values are latched only at PWM period boundaries, so LED outputs never glitch mid-period.

Parameters:
- PRESCALE, 1: clk cycles per PWM count step; legal range 1..65535.

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- enable  input  1  high = PWM running; low = outputs off, counters held
- rgb  input  24  colour word: [23:16]=R, [15:8]=G, [7:0]=B
- led_r  output  1  red PWM output (registered)
- led_g  output  1  green PWM output (registered)
- led_b  output  1  blue PWM output (registered)
- period_start  output  1  one-clk pulse marking the start of each PWM period (registered)

Behaviour:
Interface:
- One clock, clk.
- Reset rst is synchronous and active-high.

Internal state:
- pre_cnt: 16 bits, counts 0..PRESCALE-1.
- pwm_cnt: 8 bits, counts 0..254. Period is 255 count steps, so 0x00 gives 0% duty and 0xFF gives 100% duty.
- Shadow duty registers: sh_r, sh_g, sh_b, 8 bits each.

Reset (rst=1 at edge, overrides everything):
- pre_cnt=0, pwm_cnt=0, sh_*=0.
- led_*=0, period_start=0.

Counting (enable=1):
- pre_cnt increments; at PRESCALE-1 it wraps to 0 and asserts an internal tick.
- On tick, pwm_cnt increments; 254 wraps to 0.
- With PRESCALE=1, tick occurs every cycle.

Load point (cycle where enable=1, pre_cnt=0 and pwm_cnt=0):
- Duty source is rgb directly, and sh_* <= rgb fields at that edge.
- In all other cycles, duty source is sh_*.
- rgb changes outside the load point have no effect until the next period.

Outputs (registered, one-cycle latency from counter state):
- led_x <= enable && (pwm_cnt < duty_x).
- period_start <= enable && pre_cnt==0 && pwm_cnt==0.

Duty rules:
- High time per period = duty_x × PRESCALE clks.
- Low time = (255 - duty_x) × PRESCALE clks.
- Unsigned 8-bit compare.

enable=0:
- pre_cnt and pwm_cnt forced to 0.
- led_*=0 and period_start=0 at the next edge.
- sh_* retained.
- When enable returns to 1, the first enabled cycle is a load point: new period begins and fresh rgb is sampled.

Simultaneous events:
- rst beats enable.
- At the load point, the rgb sample wins over the old shadow.
- enable falling on the load cycle means no load occurs.

Reset mid-period:
- Period aborted; outputs low next edge.
- If enable=1 after release, the next period starts on the first cycle after rst deasserts.

Optional Feature:
Macro RGB_PWM_ACTIVE_LOW_EN, for common-anode LEDs.
- Defined:
  - led_r, led_g, led_b are inverted at the register input (low = LED on).
  - Reset value of led_* is 1.
  - enable=0 drives led_* to 1.
  - period_start is unaffected.
- Undefined: active-high outputs as described above.

Test Plan:
All cases use PRESCALE=1 unless stated.
1. rst held 3 clks, rgb=FFFFFF, enable=1 -> led_r/g/b=0 and period_start=0 throughout reset; period_start first pulses 1 clk after rst release.
2. rgb=FF0000, enable=1 for 3 periods -> led_r constantly 1, led_g=led_b=0; period_start pulses exactly every 255 clks.
3. rgb=000080 -> led_b high 128 clks then low 127 clks each period. Repeat with PRESCALE=4 -> 512 clks high, 508 low, period_start every 1020 clks.
4. rgb=000000, then rgb=00FF00 applied 100 clks into a period -> led_g stays 0 for the rest of that period, goes high 1 clk after the next period_start, then stays 1.
5. enable dropped 50 clks into a period with rgb=FFFFFF -> led_*=0 on the next edge; on re-enable with rgb=00FFFF, period_start 1 clk later, led_r=0, led_g=led_b=1.
6. rst asserted 1 clk mid-period with rgb=808080 -> led_*=0 the edge after; after release, a fresh period with 128 high clks per channel. With RGB_PWM_ACTIVE_LOW_EN defined, rerun case 2 -> led_r constantly 0, led_g=led_b=1, reset value of led_*=1.
